// File: rtl/regfile_csr_pkg.sv
// Shared core defines: CSR addresses, mstatus bit positions and CSR write-masking helpers.
package regfile_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  // True only for CSRs that accept software writes (mhartid and holes excluded).
  function automatic logic csr_writable(input logic [11:0] addr);
    logic w;
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH: w = 1'b1;
      default:                              w = 1'b0;
    endcase
    return w;
  endfunction

  // Value as it would read back after being stored at addr.
  function automatic logic [31:0] csr_mask(input logic [11:0] addr, input logic [31:0] wdata);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (addr)
      CSR_MSTATUS: begin
        w[MSTATUS_MIE_BIT]  = wdata[MSTATUS_MIE_BIT];
        w[MSTATUS_MPIE_BIT] = wdata[MSTATUS_MPIE_BIT];
      end
      CSR_MTVEC, CSR_MEPC:                         w = {wdata[31:2], 2'b00};
      CSR_MSCRATCH, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH: w = wdata;
      default:                                     w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/regfile_csr_csr_unit.sv
// Machine-mode CSR storage, write masking, read bypass and the 64-bit cycle counter.
module csr_unit
  import regfile_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_csr_wdata_i,
  input  logic [11:0] wb_csr_waddr_i,
  input  logic        wb_csr_we_i,
  input  logic [11:0] id_csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic        csr_mie_o
);

  logic        r_mie, r_mpie;
  logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mcycle, r_mcycleh;
  logic [31:0] w_wmasked, w_stored, w_rdata;
  logic [63:0] w_cyc_next;

  assign w_wmasked  = csr_mask(wb_csr_waddr_i, wb_csr_wdata_i);
  assign w_cyc_next = {r_mcycleh, r_mcycle} + 64'd1;

  // Software-visible CSR storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= {MTVEC_RST[31:2], 2'b00};
      r_mscratch <= 32'h0000_0000;
      r_mepc     <= 32'h0000_0000;
      r_mcause   <= 32'h0000_0000;
    end else if (wb_csr_we_i) begin
      case (wb_csr_waddr_i)
        CSR_MSTATUS: begin
          r_mie  <= w_wmasked[MSTATUS_MIE_BIT];
          r_mpie <= w_wmasked[MSTATUS_MPIE_BIT];
        end
        CSR_MTVEC:    r_mtvec    <= w_wmasked;
        CSR_MSCRATCH: r_mscratch <= w_wmasked;
        CSR_MEPC:     r_mepc     <= w_wmasked;
        CSR_MCAUSE:   r_mcause   <= w_wmasked;
        default:      ;
      endcase
    end
  end

  // A write to either half replaces that half and skips this cycle's increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcycle  <= 32'h0000_0000;
      r_mcycleh <= 32'h0000_0000;
    end else if (wb_csr_we_i && (wb_csr_waddr_i == CSR_MCYCLE)) begin
      r_mcycle <= wb_csr_wdata_i;
    end else if (wb_csr_we_i && (wb_csr_waddr_i == CSR_MCYCLEH)) begin
      r_mcycleh <= wb_csr_wdata_i;
    end else begin
      {r_mcycleh, r_mcycle} <= w_cyc_next;
    end
  end

  // Read mux with same-cycle bypass of writable CSRs
  always_comb begin
    w_stored = 32'h0000_0000;
    case (id_csr_raddr_i)
      CSR_MSTATUS: begin
        w_stored[MSTATUS_MIE_BIT]  = r_mie;
        w_stored[MSTATUS_MPIE_BIT] = r_mpie;
      end
      CSR_MTVEC:    w_stored = r_mtvec;
      CSR_MSCRATCH: w_stored = r_mscratch;
      CSR_MEPC:     w_stored = r_mepc;
      CSR_MCAUSE:   w_stored = r_mcause;
      CSR_MCYCLE:   w_stored = r_mcycle;
      CSR_MCYCLEH:  w_stored = r_mcycleh;
      default:      w_stored = 32'h0000_0000;
    endcase
    if (wb_csr_we_i && csr_writable(wb_csr_waddr_i) && (wb_csr_waddr_i == id_csr_raddr_i)) begin
      w_rdata = w_wmasked;
    end else begin
      w_rdata = w_stored;
    end
  end

  assign csr_rdata_o = w_rdata;
  assign csr_mtvec_o = r_mtvec;
  assign csr_mepc_o  = r_mepc;
  assign csr_mie_o   = r_mie;

endmodule

// File: rtl/regfile_csr.sv
// Integer register file (x1..x31, x0 hardwired zero) with write-through bypass, plus the CSR unit.
module regfile_csr
  import regfile_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_reg_wdata_i,
  input  logic [4:0]  wb_reg_waddr_i,
  input  logic        wb_reg_we_i,
  input  logic [31:0] wb_csr_wdata_i,
  input  logic [11:0] wb_csr_waddr_i,
  input  logic        wb_csr_we_i,
  input  logic [4:0]  id_rs1_raddr_i,
  input  logic [4:0]  id_rs2_raddr_i,
  output logic [31:0] regs_rs1_rdata_o,
  output logic [31:0] regs_rs2_rdata_o,
  input  logic [11:0] id_csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic        csr_mie_o
);

  logic [31:0] r_regs [1:31];
  logic [31:0] w_rs1, w_rs2;
  logic        w_wr_en;

  assign w_wr_en = wb_reg_we_i && (wb_reg_waddr_i != 5'd0);

  // GPR array; x0 has no storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= 32'h0000_0000;
      end
    end else if (w_wr_en) begin
      r_regs[wb_reg_waddr_i] <= wb_reg_wdata_i;
    end
  end

  // Combinational read ports with write-through bypass
  always_comb begin
    w_rs1 = 32'h0000_0000;
    w_rs2 = 32'h0000_0000;
    if (id_rs1_raddr_i == 5'd0) begin
      w_rs1 = 32'h0000_0000;
    end else if (w_wr_en && (wb_reg_waddr_i == id_rs1_raddr_i)) begin
      w_rs1 = wb_reg_wdata_i;
    end else begin
      w_rs1 = r_regs[id_rs1_raddr_i];
    end
    if (id_rs2_raddr_i == 5'd0) begin
      w_rs2 = 32'h0000_0000;
    end else if (w_wr_en && (wb_reg_waddr_i == id_rs2_raddr_i)) begin
      w_rs2 = wb_reg_wdata_i;
    end else begin
      w_rs2 = r_regs[id_rs2_raddr_i];
    end
  end

  assign regs_rs1_rdata_o = w_rs1;
  assign regs_rs2_rdata_o = w_rs2;

  csr_unit #(
    .MTVEC_RST (MTVEC_RST)
  ) u_csr_unit (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_csr_wdata_i (wb_csr_wdata_i),
    .wb_csr_waddr_i (wb_csr_waddr_i),
    .wb_csr_we_i    (wb_csr_we_i),
    .id_csr_raddr_i (id_csr_raddr_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_mtvec_o    (csr_mtvec_o),
    .csr_mepc_o     (csr_mepc_o),
    .csr_mie_o      (csr_mie_o)
  );

endmodule

// File: tb/tb_regfile_csr.sv
// Directed self-checking bench for regfile_csr: inputs change on the falling edge, outputs sampled 1ns later.
module tb_regfile_csr;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] MTVEC_EXP = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_reg_wdata_i;
  logic [4:0]  wb_reg_waddr_i;
  logic        wb_reg_we_i;
  logic [31:0] wb_csr_wdata_i;
  logic [11:0] wb_csr_waddr_i;
  logic        wb_csr_we_i;
  logic [4:0]  id_rs1_raddr_i;
  logic [4:0]  id_rs2_raddr_i;
  logic [31:0] regs_rs1_rdata_o;
  logic [31:0] regs_rs2_rdata_o;
  logic [11:0] id_csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic [31:0] csr_mtvec_o;
  logic [31:0] csr_mepc_o;
  logic        csr_mie_o;

  int n_vec;
  int n_err;

  regfile_csr #(.MTVEC_RST(MTVEC_RST)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_reg_wdata_i   (wb_reg_wdata_i),
    .wb_reg_waddr_i   (wb_reg_waddr_i),
    .wb_reg_we_i      (wb_reg_we_i),
    .wb_csr_wdata_i   (wb_csr_wdata_i),
    .wb_csr_waddr_i   (wb_csr_waddr_i),
    .wb_csr_we_i      (wb_csr_we_i),
    .id_rs1_raddr_i   (id_rs1_raddr_i),
    .id_rs2_raddr_i   (id_rs2_raddr_i),
    .regs_rs1_rdata_o (regs_rs1_rdata_o),
    .regs_rs2_rdata_o (regs_rs2_rdata_o),
    .id_csr_raddr_i   (id_csr_raddr_i),
    .csr_rdata_o      (csr_rdata_o),
    .csr_mtvec_o      (csr_mtvec_o),
    .csr_mepc_o       (csr_mepc_o),
    .csr_mie_o        (csr_mie_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_reg_we_i    = 1'b0;
    wb_reg_waddr_i = 5'd0;
    wb_reg_wdata_i = 32'h0;
    wb_csr_we_i    = 1'b0;
    wb_csr_waddr_i = 12'h000;
    wb_csr_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    id_rs1_raddr_i = 5'd9;
    id_rs2_raddr_i = 5'd31;
    id_csr_raddr_i = 12'hB00;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_mcycle0 got=%h exp=%h", csr_rdata_o, 32'h0);
    end
    n_vec++;
    if (csr_mtvec_o !== MTVEC_EXP) begin
      n_err++; $display("FAIL reset_mtvec got=%h exp=%h", csr_mtvec_o, MTVEC_EXP);
    end
    n_vec++;
    if (regs_rs1_rdata_o !== 32'h0 || regs_rs2_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_gpr got=%h/%h exp=0", regs_rs1_rdata_o, regs_rs2_rdata_o);
    end
    n_vec++;
    if (csr_mepc_o !== 32'h0 || csr_mie_o !== 1'b0) begin
      n_err++; $display("FAIL reset_mepc_mie got=%h/%b exp=0/0", csr_mepc_o, csr_mie_o);
    end
    next_cycle();
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h1) begin
      n_err++; $display("FAIL count_start got=%h exp=%h", csr_rdata_o, 32'h1);
    end
  endtask

  task automatic test_gpr_bypass();
    next_cycle();
    wb_reg_we_i = 1'b1; wb_reg_waddr_i = 5'd5; wb_reg_wdata_i = 32'hDEAD_BEEF;
    id_rs1_raddr_i = 5'd5; id_rs2_raddr_i = 5'd5;
    #1;
    n_vec++;
    if (regs_rs1_rdata_o !== 32'hDEAD_BEEF || regs_rs2_rdata_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL gpr_bypass got=%h/%h exp=deadbeef", regs_rs1_rdata_o, regs_rs2_rdata_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_vec++;
    if (regs_rs1_rdata_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL gpr_stored got=%h exp=deadbeef", regs_rs1_rdata_o);
    end
  endtask

  task automatic test_x0();
    next_cycle();
    wb_reg_we_i = 1'b1; wb_reg_waddr_i = 5'd0; wb_reg_wdata_i = 32'h0000_1234;
    id_rs1_raddr_i = 5'd0; id_rs2_raddr_i = 5'd0;
    #1;
    n_vec++;
    if (regs_rs1_rdata_o !== 32'h0 || regs_rs2_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL x0_same got=%h/%h exp=0", regs_rs1_rdata_o, regs_rs2_rdata_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_vec++;
    if (regs_rs1_rdata_o !== 32'h0 || regs_rs2_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL x0_next got=%h/%h exp=0", regs_rs1_rdata_o, regs_rs2_rdata_o);
    end
  endtask

  task automatic test_gpr_many();
    for (int i = 1; i < 32; i++) begin
      next_cycle();
      wb_reg_we_i = 1'b1; wb_reg_waddr_i = 5'(i); wb_reg_wdata_i = 32'hA500_0000 + 32'(i);
    end
    next_cycle();
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      id_rs1_raddr_i = 5'(i);
      id_rs2_raddr_i = 5'(32 - i);
      #1;
      n_vec++;
      if (regs_rs1_rdata_o !== 32'hA500_0000 + 32'(i) ||
          regs_rs2_rdata_o !== 32'hA500_0000 + 32'(32 - i)) begin
        n_err++; $display("FAIL gpr_readback x%0d got=%h/%h", i, regs_rs1_rdata_o, regs_rs2_rdata_o);
      end
    end
  endtask

  task automatic test_csr_mask();
    next_cycle();
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'h305; wb_csr_wdata_i = 32'h8000_0107;
    id_csr_raddr_i = 12'h305;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h8000_0104 || csr_mtvec_o !== MTVEC_EXP) begin
      n_err++; $display("FAIL mtvec_bypass got=%h/%h exp=80000104/%h", csr_rdata_o, csr_mtvec_o, MTVEC_EXP);
    end
    next_cycle();
    wb_csr_waddr_i = 12'h300; wb_csr_wdata_i = 32'hFFFF_FFFF;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h8000_0104 || csr_mtvec_o !== 32'h8000_0104) begin
      n_err++; $display("FAIL mtvec_stored got=%h/%h exp=80000104", csr_rdata_o, csr_mtvec_o);
    end
    next_cycle();
    wb_csr_waddr_i = 12'h341; wb_csr_wdata_i = 32'h0000_1237;
    id_csr_raddr_i = 12'h300;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0000_0088 || csr_mie_o !== 1'b1) begin
      n_err++; $display("FAIL mstatus got=%h mie=%b exp=00000088/1", csr_rdata_o, csr_mie_o);
    end
    next_cycle();
    wb_csr_waddr_i = 12'h342; wb_csr_wdata_i = 32'h8000_000B;
    id_csr_raddr_i = 12'h341;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0000_1234 || csr_mepc_o !== 32'h0000_1234) begin
      n_err++; $display("FAIL mepc got=%h/%h exp=00001234", csr_rdata_o, csr_mepc_o);
    end
    next_cycle();
    wb_csr_waddr_i = 12'h340; wb_csr_wdata_i = 32'hFFFF_FFFF;
    id_csr_raddr_i = 12'h342;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h8000_000B) begin
      n_err++; $display("FAIL mcause got=%h exp=8000000b", csr_rdata_o);
    end
    next_cycle();
    wb_csr_waddr_i = 12'h123; wb_csr_wdata_i = 32'h5555_5555;
    id_csr_raddr_i = 12'h340;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL mscratch got=%h exp=ffffffff", csr_rdata_o);
    end
    id_csr_raddr_i = 12'h123;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL unimpl_bypass got=%h exp=0", csr_rdata_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL unimpl_read got=%h exp=0", csr_rdata_o);
    end
  endtask

  task automatic test_counter();
    next_cycle();
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'hB00; wb_csr_wdata_i = 32'hFFFF_FFFE;
    id_csr_raddr_i = 12'hB00;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL mcycle_bypass got=%h exp=fffffffe", csr_rdata_o);
    end
    next_cycle();
    wb_csr_waddr_i = 12'hB80; wb_csr_wdata_i = 32'h0;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL mcycle_held got=%h exp=fffffffe", csr_rdata_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL mcycle_no_inc got=%h exp=fffffffe", csr_rdata_o);
    end
    next_cycle();
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL mcycle_inc got=%h exp=ffffffff", csr_rdata_o);
    end
    next_cycle();
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL mcycle_wrap got=%h exp=0", csr_rdata_o);
    end
    id_csr_raddr_i = 12'hB80;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h1) begin
      n_err++; $display("FAIL mcycleh_carry got=%h exp=1", csr_rdata_o);
    end
    next_cycle();
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'hF14; wb_csr_wdata_i = 32'h5;
    id_csr_raddr_i = 12'hF14;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL mhartid_bypass got=%h exp=0", csr_rdata_o);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL mhartid got=%h exp=0", csr_rdata_o);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    wb_reg_we_i = 1'b1; wb_reg_waddr_i = 5'd7; wb_reg_wdata_i = 32'h0000_0055;
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'h341; wb_csr_wdata_i = 32'h0000_0100;
    next_cycle();
    rst_n = 1'b0;
    wb_reg_we_i = 1'b1; wb_reg_waddr_i = 5'd7; wb_reg_wdata_i = 32'h0000_AAAA;
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'h340; wb_csr_wdata_i = 32'h0000_7777;
    id_rs1_raddr_i = 5'd7; id_rs2_raddr_i = 5'd5;
    id_csr_raddr_i = 12'h340;
    #1;
    n_vec++;
    if (regs_rs1_rdata_o !== 32'h0000_AAAA || csr_rdata_o !== 32'h0000_7777) begin
      n_err++; $display("FAIL rst_bypass got=%h/%h exp=0000aaaa/00007777", regs_rs1_rdata_o, csr_rdata_o);
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    id_csr_raddr_i = 12'hB00;
    #1;
    n_vec++;
    if (regs_rs1_rdata_o !== 32'h0 || regs_rs2_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL rst_gpr got=%h/%h exp=0", regs_rs1_rdata_o, regs_rs2_rdata_o);
    end
    n_vec++;
    if (csr_rdata_o !== 32'h0 || csr_mepc_o !== 32'h0) begin
      n_err++; $display("FAIL rst_mcycle_mepc got=%h/%h exp=0", csr_rdata_o, csr_mepc_o);
    end
    n_vec++;
    if (csr_mtvec_o !== MTVEC_EXP || csr_mie_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mtvec_mie got=%h/%b exp=%h/0", csr_mtvec_o, csr_mie_o, MTVEC_EXP);
    end
    id_csr_raddr_i = 12'h340;
    #1;
    n_vec++;
    if (csr_rdata_o !== 32'h0) begin
      n_err++; $display("FAIL rst_mscratch got=%h exp=0", csr_rdata_o);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_gpr_bypass();
    test_x0();
    test_gpr_many();
    test_csr_mask();
    test_counter();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_csr.md
REGFILE_CSR -- requirements
Module: regfile_csr

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports wb_reg_wdata_i / wb_reg_waddr_i / wb_reg_we_i  input  32/5/1  GPR write port driven by the writeback stage.
REQ-005 SHALL have ports wb_csr_wdata_i / wb_csr_waddr_i / wb_csr_we_i  input  32/12/1  CSR write port driven by the writeback stage.
REQ-006 SHALL have ports id_rs1_raddr_i, id_rs2_raddr_i  input  5  GPR read addresses from decode.
REQ-007 SHALL have ports regs_rs1_rdata_o, regs_rs2_rdata_o  output  32  GPR read data.
REQ-008 SHALL have port id_csr_raddr_i  input  12  CSR read address; csr_rdata_o  output  32  CSR read data.
REQ-009 SHALL have ports csr_mtvec_o, csr_mepc_o  output  32, and csr_mie_o  output  1, giving live CSR state to the flow controller.

Function
REQ-010 SHALL hold 31 GPRs x1..x31; x0 SHALL read 0, and writes to x0 SHALL be discarded.
REQ-011 SHALL write a GPR at the clock edge when wb_reg_we_i=1 and waddr!=0; latency 1 cycle.
REQ-012 SHALL make GPR reads combinational, with write-through bypass: if we=1, waddr!=0 and waddr==raddr, the output SHALL equal wb_reg_wdata_i in the same cycle.
REQ-013 SHALL let both read ports hit the same or the written register simultaneously with no conflict.
REQ-014 SHALL implement these CSRs: mstatus 0x300 (only MIE bit3 and MPIE bit7 stored; all other bits read 0); mtvec 0x305 (bits[1:0] read 0); mscratch 0x340 (full 32 bits); mepc 0x341 (bits[1:0] read 0); mcause 0x342 (full 32 bits); mcycle 0xB00; mcycleh 0xB80; mhartid 0xF14 (read-only, 0).
REQ-015 SHALL return 0 on reads of unimplemented CSR addresses, and SHALL ignore writes to them and to mhartid.
REQ-016 SHALL write a CSR at the clock edge when wb_csr_we_i=1; storage masking is per REQ-014.
REQ-017 SHALL bypass CSR reads: if we=1, the address is writable and waddr==raddr, csr_rdata_o SHALL equal wb_csr_wdata_i masked per REQ-014.
REQ-018 SHALL implement a 64-bit cycle counter {mcycleh,mcycle} that increments by 1 every cycle out of reset, wrapping from 2^64-1 to 0.
REQ-019 SHALL, on a CSR write to mcycle or mcycleh, load the written half with wdata, hold the other half, and suppress that cycle's increment.
REQ-020 SHALL propagate a carry into mcycleh when mcycle wraps 0xFFFF_FFFF->0 without a write in that cycle.
REQ-021 SHALL drive csr_mtvec_o, csr_mepc_o and csr_mie_o from stored (registered) values, not bypassed.

Reset
REQ-022 SHALL, while rst_n=0 at a clock edge, clear all GPRs, mstatus, mscratch, mepc, mcause and the cycle counter, and set mtvec to MTVEC_RST with bits[1:0]=0.
REQ-023 SHALL give writes presented during reset no effect; reads SHALL remain combinational, with bypass still applied.
REQ-024 SHALL start counting the first cycle after rst_n rises; the cycle counter SHALL read 0 in the first cycle after reset.

Structure
REQ-025 SHALL take CSR address constants and the mstatus bit positions from the shared core defines package.
REQ-026 SHALL isolate the CSR storage, masking and counter in a sub-module csr_unit, keeping the GPR array in the top module.

Verification
REQ-027 SHALL cover GPR write and bypass: write x5=32'hDEAD_BEEF, with rs1=5 in the same cycle -> rs1 reads DEAD_BEEF combinationally and still reads it the next cycle.
REQ-028 SHALL cover x0: write x0=32'h1234 with rs1=rs2=0 -> both ports read 0 in that cycle and the next.
REQ-029 SHALL cover CSR masking: write mtvec=32'h8000_0107 -> csr_rdata_o and csr_mtvec_o read 32'h8000_0104 next cycle; write mstatus=32'hFFFF_FFFF -> reads 32'h0000_0088, and csr_mie_o=1.
REQ-030 SHALL cover the counter: write mcycle=32'hFFFF_FFFE and mcycleh=0 -> two cycles later mcycle=0 and mcycleh=1; write mhartid=5 -> reads 0.
REQ-031 SHALL cover mid-operation reset: after nonzero writes, hold rst_n=0 for one edge while wb_reg_we_i=1 -> all GPRs, mepc and mcycle read 0, and mtvec reads MTVEC_RST.
